// File: rtl/d8m_cfg_pkg.sv
// d8m_cfg_pkg: shared types and constants for the D8M register configuration sequencer.
package d8m_cfg_pkg;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [15:0] REG_DELAY    = 16'hFFFF;
    localparam logic [15:0] REG_END      = 16'hFFFE;
    localparam int          ENTRY_W      = 24;
    localparam logic [7:0]  DEV_ADDR_DEF = 8'h6C;

    typedef struct packed {
        logic [15:0] regaddr;
        logic [7:0]  data;
    } entry_t;

endpackage

// File: rtl/d8m_cfg_if.sv
// d8m_cfg_if: write-command and transfer-result handshake between the sequencer and the I2C master.
interface d8m_cfg_if;

    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_DEV;
    logic [15:0] CMD_REG;
    logic [7:0]  CMD_DATA;
    logic        XFER_DONE;
    logic        XFER_NACK;

    modport master (
        output CMD_VALID, CMD_DEV, CMD_REG, CMD_DATA,
        input  CMD_READY, XFER_DONE, XFER_NACK
    );

    modport slave (
        input  CMD_VALID, CMD_DEV, CMD_REG, CMD_DATA,
        output CMD_READY, XFER_DONE, XFER_NACK
    );

endinterface

// File: rtl/d8m_cfg_rom.sv
// d8m_cfg_rom: sensor bring-up table, synchronous read with one cycle of latency.
module d8m_cfg_rom
    import d8m_cfg_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    output entry_t        entry
);

    // Entries past the populated list read as the end marker.
    function automatic entry_t lookup(input int a);
        case (a)
            0:       lookup = {16'h0103, 8'h01};
            1:       lookup = {16'h0100, 8'h00};
            2:       lookup = {16'h3034, 8'h1A};
            3:       lookup = {REG_DELAY, 8'h03};
            4:       lookup = {16'h3035, 8'h21};
            5:       lookup = {16'h0100, 8'h01};
            6:       lookup = {REG_DELAY, 8'h00};
            default: lookup = {REG_END, 8'h00};
        endcase
    endfunction

    always_ff @(posedge clk)
        entry <= lookup(int'(idx));

endmodule

// File: rtl/d8m_cfg_sequencer.sv
// d8m_cfg_sequencer: walks the register table after power-up or restart, issuing one I2C write per entry
// with NACK retry and delay entries, then reports done or error.
module d8m_cfg_sequencer
    import d8m_cfg_pkg::*;
#(
    parameter int         NUM_REGS       = 64,
    parameter int         POWERUP_CYCLES = 1000000,
    parameter int         DELAY_UNIT     = 50000,
    parameter int         MAX_RETRY      = 3,
    parameter logic [7:0] DEV_ADDR       = DEV_ADDR_DEF,
    localparam int        IW             = $clog2(NUM_REGS)
) (
    input  logic          CLOCK_50,
    input  logic          RESET_SYS_N,
    input  logic          CFG_START,
    d8m_cfg_if.master     cmd,
    output logic          CFG_BUSY,
    output logic          CFG_DONE,
    output logic          CFG_ERR,
    output logic [IW-1:0] CFG_IDX
);

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [31:0]   cnt, cnt_n;
    logic [7:0]    retry, retry_n;
    logic [15:0]   reg_q, reg_n;
    logic [7:0]    data_q, data_n;
    logic          busy;
    entry_t        entry;

    d8m_cfg_rom #(.AW(IW)) u_rom (
        .clk   (CLOCK_50),
        .idx   (idx),
        .entry (entry)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        retry_n = retry;
        reg_n   = reg_q;
        data_n  = data_q;
        case (state)
            S_PWRUP: begin
                cnt_n   = (cnt == 32'(POWERUP_CYCLES - 1)) ? '0 : cnt + 32'd1;
                state_n = (cnt == 32'(POWERUP_CYCLES - 1)) ? S_FETCH : S_PWRUP;
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (entry.regaddr == REG_END)
                    state_n = S_DONE;
                else if (entry.regaddr == REG_DELAY) begin
                    cnt_n   = 32'(entry.data) * 32'(DELAY_UNIT);
                    state_n = (entry.data == 8'd0) ? S_NEXT : S_DELAY;
                end else begin
                    reg_n   = entry.regaddr;
                    data_n  = entry.data;
                    retry_n = '0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = cmd.CMD_READY ? S_WAIT : S_ISSUE;
            S_WAIT: if (cmd.XFER_DONE) begin
                state_n = !cmd.XFER_NACK ? S_NEXT : (retry < 8'(MAX_RETRY)) ? S_ISSUE : S_FAIL;
                retry_n = (cmd.XFER_NACK && retry < 8'(MAX_RETRY)) ? retry + 8'd1 : retry;
            end
            // Loaded with the full count in DECODE, so DELAY lasts exactly data*DELAY_UNIT cycles.
            S_DELAY: begin
                cnt_n   = (cnt <= 32'd1) ? '0 : cnt - 32'd1;
                state_n = (cnt <= 32'd1) ? S_NEXT : S_DELAY;
            end
            S_NEXT: begin
                idx_n   = (idx == IW'(NUM_REGS - 1)) ? idx : idx + IW'(1);
                state_n = (idx == IW'(NUM_REGS - 1)) ? S_DONE : S_FETCH;
            end
            default: ;
        endcase
        if (CFG_START) begin
            state_n = S_PWRUP;
            idx_n   = '0;
            cnt_n   = '0;
            retry_n = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_SYS_N)
        if (!RESET_SYS_N) begin
            state  <= S_PWRUP;
            idx    <= '0;
            cnt    <= '0;
            retry  <= '0;
            reg_q  <= '0;
            data_q <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            retry  <= retry_n;
            reg_q  <= reg_n;
            data_q <= data_n;
            busy   <= !(state_n inside {S_DONE, S_FAIL});
        end

    assign cmd.CMD_VALID = (state == S_ISSUE);
    assign cmd.CMD_DEV   = DEV_ADDR;
    assign cmd.CMD_REG   = reg_q;
    assign cmd.CMD_DATA  = data_q;
    assign CFG_BUSY      = busy;
    assign CFG_DONE      = (state == S_DONE);
    assign CFG_ERR       = (state == S_FAIL);
    assign CFG_IDX       = idx;

endmodule
